// File: rtl/haar_pkg.sv
// Shared constants and FSM encoding for the Haar front end.
// Both the integral image builder and the classifier stage import this
// package so that window geometry and word widths stay in one place.
//   IMG_WIDTH / IMG_HEIGHT : window size in pixels
//   PIX_W                  : unsigned pixel width
//   II_W                   : integral word width (holds W*H*(2^PIX_W-1))
//   ADDR_W                 : integral-image RAM address width
package haar_pkg;

    localparam int IMG_WIDTH  = 20;
    localparam int IMG_HEIGHT = 20;
    localparam int PIX_W      = 8;
    localparam int II_W       = 17;
    localparam int ADDR_W     = 9;

    localparam int NUM_PIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam int X_W        = $clog2(IMG_WIDTH);
    localparam int Y_W        = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ii_state_t;

    function automatic logic [II_W-1:0] pix_to_ii(input logic [PIX_W-1:0] pix);
        return {{(II_W-PIX_W){1'b0}}, pix};
    endfunction

endpackage

// File: rtl/integral_image_builder_if.sv
// Pixel-stream / RAM-write bundle of the integral image builder.
//   start, pix_data, pix_valid      : upstream control and pixel stream
//   pix_ready                       : builder accepts a pixel this cycle
//   wr_en, wr_addr, wr_data         : integral-image RAM write port
//   busy, frame_done                : window status
// slave  : the builder's view
// master : the view of whatever sources pixels and consumes status
interface integral_image_builder_if;
    import haar_pkg::*;

    logic              start;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [II_W-1:0]   wr_data;
    logic              busy;
    logic              frame_done;

    modport slave (
        input  start, pix_data, pix_valid,
        output pix_ready, wr_en, wr_addr, wr_data, busy, frame_done
    );

    modport master (
        output start, pix_data, pix_valid,
        input  pix_ready, wr_en, wr_addr, wr_data, busy, frame_done
    );

endinterface

// File: rtl/ii_line_buffer.sv
// One-row line buffer holding the integral values of the previous row.
// Asynchronous read, synchronous write, no reset: every entry is written
// in row 0 before it is ever read (row 0 ignores the buffer).
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : column to write
//   wr_data  : integral value to store
//   rd_addr  : column to read
//   rd_data  : stored integral value (combinational)
module ii_line_buffer #(
    parameter int DEPTH  = 20,
    parameter int DATA_W = 17,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/integral_image_builder.sv
// Integral image builder: turns a raster-order pixel window into the
// inclusive integral image and writes each word to the shared RAM at
// address x + y*IMG_WIDTH, one word per accepted pixel.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : slave side of integral_image_builder_if (pixel stream in,
//            RAM write port, busy/frame_done status out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start (ignored in the cycle frame_done is high)
// RUN   | accepting pixels, one integral word written per transfer
// FLUSH | last word is on the write port; frame_done follows
module integral_image_builder
    import haar_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    integral_image_builder_if.slave bus
);

    ii_state_t         state, state_nxt;

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [II_W-1:0]   row_sum;
    logic [ADDR_W-1:0] addr_cnt;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [II_W-1:0]   wr_data_q;
    logic              frame_done_q;

    logic              xfer;
    logic              x_last, y_last, last_pix;
    logic              accept_start;
    logic [II_W-1:0]   lb_rd, rs, up, ii;

    assign xfer     = bus.pix_valid && (state == RUN);
    assign x_last   = (x == X_W'(IMG_WIDTH - 1));
    assign y_last   = (y == Y_W'(IMG_HEIGHT - 1));
    assign last_pix = x_last && y_last;

    // frame_done_q is high exactly in the first IDLE cycle after a window;
    // a start landing there belongs to the old window's handshake and is dropped.
    assign accept_start = (state == IDLE) && bus.start && !frame_done_q;

    always_comb begin
        rs = ((x == '0) ? '0 : row_sum) + pix_to_ii(bus.pix_data);
        up = (y == '0) ? '0 : lb_rd;
        ii = rs + up;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_start)     state_nxt = RUN;
            RUN:     if (xfer && last_pix) state_nxt = FLUSH;
            FLUSH:                         state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x            <= '0;
            y            <= '0;
            row_sum      <= '0;
            addr_cnt     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_en_q      <= xfer;
            frame_done_q <= (state == FLUSH);

            if (accept_start) begin
                x        <= '0;
                y        <= '0;
                row_sum  <= '0;
                addr_cnt <= '0;
            end

            if (xfer) begin
                row_sum   <= rs;
                wr_data_q <= ii;
                wr_addr_q <= addr_cnt;
                // Raster order makes x + y*IMG_WIDTH a plain running count.
                addr_cnt  <= last_pix ? '0 : addr_cnt + 1'b1;
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    ii_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (II_W),
        .AW     (X_W)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (xfer),
        .wr_addr (x),
        .wr_data (ii),
        .rd_addr (x),
        .rd_data (lb_rd)
    );

    assign bus.pix_ready  = (state == RUN);
    assign bus.busy       = (state != IDLE);
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_integral_image_builder.sv
module tb_integral_image_builder;
    import haar_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    integral_image_builder_if bus();

    integral_image_builder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // RAM model and write-port monitor
    logic [II_W-1:0]   mem [NUM_PIX];
    logic [ADDR_W-1:0] exp_addr;
    int wr_cnt = 0, fd_cnt = 0, cyc = 0;
    int last_wr_cyc = -10, fd_cyc = -20, addr_err = 0;
    logic busy_at_fd = 1'b1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_addr = '0;
        end else begin
            cyc++;
            if (bus.wr_en) begin
                if (int'(bus.wr_addr) < NUM_PIX) mem[bus.wr_addr] = bus.wr_data;
                if (bus.wr_addr != exp_addr) addr_err++;
                exp_addr = (int'(exp_addr) == NUM_PIX - 1) ? '0 : exp_addr + 1'b1;
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (bus.frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
                busy_at_fd = bus.busy;
            end
        end
    end

    int img [NUM_PIX];
    int ref_ii [NUM_PIX];
    int ready_low = 0;

    task automatic start_pulse();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic feed(input int gap_pct, input int n, input int start_at);
        int i = 0;
        int k = 0;
        while (i < n && k < 4000) begin
            @(negedge clk);
            bus.start = (i == start_at);
            if (!bus.pix_ready) ready_low++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.pix_valid = 1'b0;
            end else begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = PIX_W'(img[i]);
            end
            if (bus.pix_valid && bus.pix_ready) i++;
            k++;
        end
        check("feed_within_budget", k < 4000, 1);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!bus.frame_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, bus.frame_done, 1);
    endtask

    task automatic compute_ref();
        for (int yy = 0; yy < IMG_HEIGHT; yy++) begin
            for (int xx = 0; xx < IMG_WIDTH; xx++) begin
                int v;
                v = img[xx + yy*IMG_WIDTH];
                if (xx > 0) v += ref_ii[xx-1 + yy*IMG_WIDTH];
                if (yy > 0) v += ref_ii[xx + (yy-1)*IMG_WIDTH];
                if (xx > 0 && yy > 0) v -= ref_ii[xx-1 + (yy-1)*IMG_WIDTH];
                ref_ii[xx + yy*IMG_WIDTH] = v;
            end
        end
    endtask

    task automatic compare_ref(input string tag);
        int bad = 0;
        compute_ref();
        for (int a = 0; a < NUM_PIX; a++) begin
            if (int'(mem[a]) != ref_ii[a]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_ones_image(input string tag);
        int bad = 0;
        for (int yy = 0; yy < IMG_HEIGHT; yy++)
            for (int xx = 0; xx < IMG_WIDTH; xx++)
                if (int'(mem[xx + yy*IMG_WIDTH]) != (xx + 1) * (yy + 1)) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        int wr0, fd0, bad;

        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: all-ones window
        for (int a = 0; a < NUM_PIX; a++) img[a] = 1;
        wr0 = wr_cnt; fd0 = fd_cnt;
        start_pulse();
        check("t1_busy_after_start", bus.busy, 1);
        feed(0, NUM_PIX, -1);
        wait_done("t1_frame_done_seen");
        check("t1_busy_in_done_cycle", bus.busy, 0);
        @(negedge clk);
        check("t1_mem0", mem[0], 1);
        check("t1_mem19", mem[19], 20);
        check("t1_mem399", mem[399], 400);
        check_ones_image("t1_image");
        check("t1_wr_count", wr_cnt - wr0, 400);
        check("t1_done_count", fd_cnt - fd0, 1);
        check("t1_done_after_last_wr", fd_cyc - last_wr_cyc, 1);
        check("t1_busy_at_done", busy_at_fd, 0);
        check("t1_frame_done_pulse", bus.frame_done, 0);

        // 2: all-255 window
        for (int a = 0; a < NUM_PIX; a++) img[a] = 255;
        start_pulse();
        feed(0, NUM_PIX, -1);
        wait_done("t2_frame_done_seen");
        @(negedge clk);
        check("t2_mem399", mem[399], 102000);
        check("t2_mem19", mem[19], 5100);
        check("t2_mem20", mem[20], 510);

        // 3: single pixel 7 at (3,2)
        for (int a = 0; a < NUM_PIX; a++) img[a] = 0;
        img[3 + 2*IMG_WIDTH] = 7;
        start_pulse();
        feed(0, NUM_PIX, -1);
        wait_done("t3_frame_done_seen");
        @(negedge clk);
        bad = 0;
        for (int yy = 0; yy < IMG_HEIGHT; yy++)
            for (int xx = 0; xx < IMG_WIDTH; xx++)
                if (int'(mem[xx + yy*IMG_WIDTH]) != ((xx >= 3 && yy >= 2) ? 7 : 0)) bad++;
        check("t3_image", bad, 0);
        check("t3_mem43", mem[43], 7);
        check("t3_mem42", mem[42], 0);

        // 4: random pixels with ~30% valid gaps
        for (int a = 0; a < NUM_PIX; a++) img[a] = int'($urandom_range(255));
        wr0 = wr_cnt;
        start_pulse();
        ready_low = 0;
        feed(30, NUM_PIX, -1);
        check("t4_ready_in_run", ready_low, 0);
        wait_done("t4_frame_done_seen");
        @(negedge clk);
        compare_ref("t4_image");
        check("t4_wr_count", wr_cnt - wr0, 400);

        // 5: reset mid-window, then a clean all-ones window
        for (int a = 0; a < NUM_PIX; a++) img[a] = 1;
        start_pulse();
        feed(0, 150, -1);
        reset = 1'b0;
        #1;
        check("t5_rst_wr_en", bus.wr_en, 0);
        check("t5_rst_wr_data", bus.wr_data, 0);
        check("t5_rst_wr_addr", bus.wr_addr, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_pix_ready", bus.pix_ready, 0);
        check("t5_rst_frame_done", bus.frame_done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr0 = wr_cnt;
        start_pulse();
        feed(0, NUM_PIX, -1);
        wait_done("t5_frame_done_seen");
        @(negedge clk);
        check_ones_image("t5_image");
        check("t5_wr_count", wr_cnt - wr0, 400);

        // 6: start during RUN and in the frame_done cycle is ignored
        for (int a = 0; a < NUM_PIX; a++) img[a] = (a % 5) + 1;
        addr_err = 0;
        wr0 = wr_cnt;
        start_pulse();
        feed(0, NUM_PIX, 123);
        wait_done("t6_frame_done_seen");
        bus.start = 1'b1;
        @(negedge clk);
        check("t6_start_in_done_ignored", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        check("t6_start_next_cycle_taken", bus.busy, 1);
        check("t6_first_window_writes", wr_cnt - wr0, 400);
        for (int a = 0; a < NUM_PIX; a++) img[a] = 1;
        feed(0, NUM_PIX, -1);
        wait_done("t6_second_done_seen");
        @(negedge clk);
        check("t6_addr_sequence", addr_err, 0);
        check_ones_image("t6_second_image");
        check("t6_total_writes", wr_cnt - wr0, 800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
